gpio_pad_ctrl: RTL

- Per-bank controller for NUM_PIN tri-state GPIO pads.
- Drives each pad's data-out, active-low output-enable and pull-enable pins from registered configuration.
- Synchronises and optionally debounces each pad's returned input, detects edges or levels, and holds sticky per-pin interrupt pending bits that combine into one irq.
- Sits between the bank's register file (config inputs, status outputs) and the pad ring.

---
 rtl/gpio_ctrl_pkg.sv | 31 +++
 rtl/gpio_debounce.sv | 60 ++++++
 rtl/gpio_pad_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/gpio_ctrl_pkg.sv
// Shared types and helpers for the GPIO pad bank controller.
// Interrupt type encoding and debounce counter sizing live here.
package gpio_ctrl_pkg;

    typedef enum logic [1:0] {
        INT_RISE = 2'b00,
        INT_FALL = 2'b01,
        INT_BOTH = 2'b10,
        INT_HIGH = 2'b11
    } int_type_e;

    localparam int DEB_LEN_DEF = 4;
    localparam int DEB_CNT_W   = $clog2(DEB_LEN_DEF);

    // Counter must hold values 0..len-1; never narrower than one bit.
    function automatic int deb_cnt_w(input int len);
        return (len < 2) ? 1 : $clog2(len);
    endfunction

    function automatic logic int_detect(input int_type_e kind, input logic cur, input logic prev);
        logic hit;
        case (kind)
            INT_RISE: hit = cur & ~prev;
            INT_FALL: hit = ~cur & prev;
            INT_BOTH: hit = cur ^ prev;
            default:  hit = cur;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One pad's input path: two-flop synchroniser followed by a tick-driven
// debounce filter that only accepts a value held for DEB_LEN ticks.
module gpio_debounce
    import gpio_ctrl_pkg::*;
#(
    parameter int DEB_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pad_in_i,
    input  logic deb_en_i,
    input  logic tick_i,
    output logic in_o
);

    localparam int CNT_W = deb_cnt_w(DEB_LEN);

    logic             sync_p0;
    logic             sync_p1;
    logic             filt_q;
    logic             filt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // pad_in_i is asynchronous; sync_p1 is the first safe-to-use copy
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_p0 <= pad_in_i;
            sync_p1 <= sync_p0;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (!deb_en_i) begin
            filt_d = sync_p1;
            cnt_d  = '0;
        end else if (sync_p1 == filt_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_W'(DEB_LEN - 1)) begin
                filt_d = sync_p1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_o = filt_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO bank controller: registered pad drive, per-pin filtered inputs,
// edge/level interrupt detection with sticky pending bits and a combined irq.
module gpio_pad_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int NUM_PIN = 8,
    parameter int DIV_W   = 16,
    parameter int DEB_LEN = DEB_LEN_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NUM_PIN-1:0]     dir_i,
    input  logic [NUM_PIN-1:0]     out_i,
    input  logic [NUM_PIN-1:0]     pull_en_i,
    input  logic [NUM_PIN-1:0]     deb_en_i,
    input  logic [DIV_W-1:0]       deb_div_i,
    input  logic [NUM_PIN-1:0]     int_en_i,
    input  logic [2*NUM_PIN-1:0]   int_type_i,
    input  logic [NUM_PIN-1:0]     int_clr_i,
    output logic [NUM_PIN-1:0]     pad_out_o,
    output logic [NUM_PIN-1:0]     pad_oen_o,
    output logic [NUM_PIN-1:0]     pad_ren_o,
    input  logic [NUM_PIN-1:0]     pad_in_i,
    output logic [NUM_PIN-1:0]     in_o,
    output logic [NUM_PIN-1:0]     int_pend_o,
    output logic                   irq_o
);

    logic [DIV_W-1:0]   pre_cnt;
    logic [DIV_W-1:0]   pre_cnt_d;
    logic               tick;
    logic [NUM_PIN-1:0] in_d;
    logic [NUM_PIN-1:0] det;
    logic [NUM_PIN-1:0] pend_q;
    logic               irq_q;

    // Pad drive; reset forces every pad to high-Z without waiting for a clock
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pad_out_o <= '0;
            pad_oen_o <= '1;
            pad_ren_o <= '0;
        end else begin
            pad_out_o <= out_i;
            pad_oen_o <= ~dir_i;
            pad_ren_o <= pull_en_i;
        end
    end

    // A divisor lowered below the running count restarts at 0 with no tick
    always_comb begin
        tick      = (pre_cnt == deb_div_i);
        pre_cnt_d = pre_cnt + DIV_W'(1);
        if (pre_cnt >= deb_div_i) begin
            pre_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_PIN; g++) begin : g_pin
        gpio_debounce #(
            .DEB_LEN (DEB_LEN)
        ) u_deb (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .pad_in_i (pad_in_i[g]),
            .deb_en_i (deb_en_i[g]),
            .tick_i   (tick),
            .in_o     (in_o[g])
        );
    end

    always_comb begin
        det = '0;
        for (int i = 0; i < NUM_PIN; i++) begin
            det[i] = int_detect(int_type_e'(int_type_i[2*i +: 2]), in_o[i], in_d[i]);
        end
    end

    // Set beats clear, so a detect coinciding with int_clr_i is never lost
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            in_d   <= '0;
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            in_d   <= in_o;
            pend_q <= (pend_q & ~int_clr_i) | det;
            irq_q  <= |(pend_q & int_en_i);
        end
    end

    assign int_pend_o = pend_q;
    assign irq_o      = irq_q;

endmodule
